// File: rtl/intc_controller.sv
// intc_controller: fixed-priority interrupt controller.
// Latches peripheral requests into PENDING, qualifies them with MASK and the
// CPU global enable, and hands the lowest-index eligible source to the CPU via
// a request / acknowledge / end-of-interrupt handshake.
//
// Handshake: int_req is a registered request that stays high while a winner
// exists. The CPU accepts it with a one-cycle int_ack; int_vec then freezes
// on the accepted source until the CPU returns with a one-cycle int_eoi.
// int_ack outside REQ and int_eoi outside SERVICE are ignored.
//
// Build option INTC_EDGE_DETECT_EN: when defined, a source event is a rising
// edge of its pin. Otherwise pins are level-sensitive and a high pin re-sets
// its pending bit every cycle.
//
// Register map (reg_addr):
//   0 MASK    r/w  bit=1 enables the source
//   1 PENDING r/w1c (a new event in the same cycle beats the clear)
//   2 VECTOR  ro   {28'b0, in_service, int_vec}
//   3 STATUS  ro   {29'b0, state[1:0], int_req}
module intc_controller #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NSRC-1:0] irq_in,
  input  logic            global_int_en,
  output logic            int_req,
  output logic [2:0]      int_vec,
  input  logic            int_ack,
  input  logic            int_eoi,
  input  logic            reg_we,
  input  logic [1:0]      reg_addr,
  input  logic [31:0]     reg_wdata,
  output logic [31:0]     reg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          state;
  logic            in_service;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] src_event;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] winner_oh;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic [2:0]      winner;
  logic            has_winner;
  logic            ack_take;
  logic            unused_wdata;

  // Upper write-data bits have no storage behind them.
  assign unused_wdata = ^reg_wdata[31:NSRC];

`ifdef INTC_EDGE_DETECT_EN
  logic [NSRC-1:0] irq_prev;

  // Edge history: previous pin levels, cleared so a pin high at reset release
  // counts as an event in the first cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) irq_prev <= '0;
    else       irq_prev <= irq_in;
  end

  assign src_event = irq_in & ~irq_prev;
`else
  assign src_event = irq_in;
`endif

  assign eligible   = global_int_en ? (pending & mask) : '0;
  assign has_winner = |eligible;

  // Fixed priority: scan from the top so the lowest eligible index wins.
  always_comb begin
    winner    = '0;
    winner_oh = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner       = 3'(i);
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
      end
    end
  end

  assign w1c      = (reg_we && reg_addr == 2'd1) ? reg_wdata[NSRC-1:0] : '0;
  assign ack_take = (state == ST_REQ) && int_ack && has_winner;
  assign ack_clr  = ack_take ? winner_oh : '0;

  // Mask register: plain read/write.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                         mask <= '0;
    else if (reg_we && reg_addr == 2'd0) mask <= reg_wdata[NSRC-1:0];
  end

  // Pending register: clears (W1C, acknowledge) first, then new events on top
  // so a simultaneous set wins. Masked sources still latch.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) pending <= '0;
    else       pending <= (pending & ~(w1c | ack_clr)) | src_event;
  end

  // Handshake FSM with registered int_req / int_vec / in_service.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      int_vec    <= 3'd0;
      in_service <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (has_winner) begin
            state   <= ST_REQ;
            int_req <= 1'b1;
            int_vec <= winner;
          end
        end
        ST_REQ: begin
          if (!has_winner) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
          end else if (int_ack) begin
            state      <= ST_SERVICE;
            int_req    <= 1'b0;
            int_vec    <= winner;
            in_service <= 1'b1;
          end else begin
            int_vec <= winner;
          end
        end
        ST_SERVICE: begin
          if (int_eoi) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; unused upper bits read as zero.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0:    reg_rdata[NSRC-1:0] = mask;
      2'd1:    reg_rdata[NSRC-1:0] = pending;
      2'd2:    reg_rdata[3:0]      = {in_service, int_vec};
      default: reg_rdata[2:0]      = {state, int_req};
    endcase
  end

endmodule
